pupil_locator: RTL and testbench

PUPIL_LOCATOR -- requirements
Module: pupil_locator

---
 rtl/pupil_locator_pkg.sv | 22 ++
 rtl/pupil_locator_divider.sv | 62 ++++++
 rtl/pupil_locator.sv | 229 ++++++++++++++++++++++
 tb/tb_pupil_locator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pupil_locator_pkg.sv
// rtl/pupil_locator_pkg.sv - shared coefficients and encodings for the pupil locator
package pupil_locator_pkg;

    localparam int GRAY_R = 77;
    localparam int GRAY_G = 151;
    localparam int GRAY_B = 28;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIV_X  = 2'd1,
        ST_DIV_Y  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_GRAY     = 2'd0,
        MODE_BINARY   = 2'd1,
        MODE_COLOUR   = 2'd2,
        MODE_GRAY_ALT = 2'd3
    } mode_t;

endpackage

// File: rtl/pupil_locator_divider.sv
// rtl/pupil_locator_divider.sv - serial restoring divider, one quotient bit per cycle
module serial_divider #(
    parameter int DVD_W = 36,
    parameter int DVS_W = 24
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem, dvs, rem_src, dvs_src, rem_next;
    logic [DVD_W-1:0] dvd_src;
    logic [DVS_W:0]   trial;
    logic             fits;
    logic [CW-1:0]    cnt;

    // The start cycle already performs the first step, so a division takes exactly DVD_W cycles.
    always_comb begin
        rem_src  = start ? '0 : rem;
        dvs_src  = start ? divisor : dvs;
        dvd_src  = start ? dividend : quotient;
        trial    = {rem_src, dvd_src[DVD_W-1]};
        fits     = (trial >= {1'b0, dvs_src});
        rem_next = fits ? DVS_W'(trial - {1'b0, dvs_src}) : trial[DVS_W-1:0];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem      <= rem_next;
                quotient <= {dvd_src[DVD_W-2:0], fits};
            end
            if (start) begin
                dvs  <= divisor;
                cnt  <= CW'(DVD_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pupil_locator.sv
// rtl/pupil_locator.sv - dark-pixel centroid tracker with gray/binary/colour video output
module pupil_locator
    import pupil_locator_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int CNT_W    = 13,
    parameter int ROI_X0   = 256,
    parameter int ROI_X1   = 640,
    parameter int BOX_HALF = 20,
    parameter int MIN_PIX  = 64,
    parameter int SUM_W    = 36,
    parameter int NPIX_W   = 24
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic [CNT_W-1:0]  iH_Cont,
    input  logic [CNT_W-1:0]  iV_Cont,
    input  logic [DATA_W-1:0] iThresh,
    input  logic [1:0]        iMode,
    input  logic              iMarkEn,
    output logic              oDVAL,
    output logic [DATA_W-1:0] oDATA_R,
    output logic [DATA_W-1:0] oDATA_G,
    output logic [DATA_W-1:0] oDATA_B,
    output logic [CNT_W-1:0]  oCX,
    output logic [CNT_W-1:0]  oCY,
    output logic              oPosValid,
    output logic              oDrop
);

    localparam int GW  = DATA_W + 9;
    localparam int SW1 = SUM_W + 1;
    localparam int NW1 = NPIX_W + 1;

    logic [GW-1:0]     gray_sum;
    logic [DATA_W-1:0] gray;
    logic              roi;

    logic              s1_dval, s1_roi;
    logic [DATA_W-1:0] s1_r, s1_g, s1_b, s1_gray;
    logic [CNT_W-1:0]  s1_h, s1_v;

    logic              dark, in_box, take, boundary, low_count;
    logic [CNT_W-1:0]  dh, dv;
    logic [DATA_W-1:0] pix_r, pix_g, pix_b;

    state_t            state;
    logic [CNT_W-1:0]  prev_v;
    logic [SUM_W-1:0]  sum_x, sum_y, snap_x, snap_y, qx, nxt_x, nxt_y, fresh_x, fresh_y;
    logic [NPIX_W-1:0] npix, snap_n, nxt_n, fresh_n;
    logic [SW1-1:0]    add_x, add_y;
    logic [NW1-1:0]    add_n;
    logic              div_kick, div_start, div_busy, div_done;
    logic [SUM_W-1:0]  div_q;

    function automatic logic [CNT_W-1:0] sat_q(input logic [SUM_W-1:0] q);
        return (q > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : q[CNT_W-1:0];
    endfunction

    assign gray_sum = GW'(GRAY_R) * GW'(iRed) + GW'(GRAY_G) * GW'(iGreen) + GW'(GRAY_B) * GW'(iBlue);
    assign gray     = DATA_W'(gray_sum >> 8);
    assign roi      = (iH_Cont >= CNT_W'(ROI_X0)) && (iH_Cont < CNT_W'(ROI_X1));

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_dval <= 1'b0;
            s1_roi  <= 1'b0;
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
            s1_gray <= '0;
            s1_h    <= '0;
            s1_v    <= '0;
        end else begin
            s1_dval <= iDVAL;
            s1_roi  <= roi;
            s1_r    <= iRed;
            s1_g    <= iGreen;
            s1_b    <= iBlue;
            s1_gray <= gray;
            s1_h    <= iH_Cont;
            s1_v    <= iV_Cont;
        end
    end

    assign dark   = s1_roi && (s1_gray < iThresh);
    assign dh     = (s1_h >= oCX) ? s1_h - oCX : oCX - s1_h;
    assign dv     = (s1_v >= oCY) ? s1_v - oCY : oCY - s1_v;
    assign in_box = iMarkEn && oPosValid && s1_roi
                    && (dh <= CNT_W'(BOX_HALF)) && (dv <= CNT_W'(BOX_HALF));

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (s1_roi && !in_box) begin
            case (mode_t'(iMode))
                MODE_BINARY: begin
                    pix_r = {DATA_W{dark}};
                    pix_g = {DATA_W{dark}};
                    pix_b = {DATA_W{dark}};
                end
                MODE_COLOUR: begin
                    pix_r = s1_r;
                    pix_g = s1_g;
                    pix_b = s1_b;
                end
                default: begin
                    pix_r = s1_gray;
                    pix_g = s1_gray;
                    pix_b = s1_gray;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL   <= 1'b0;
            oDATA_R <= '0;
            oDATA_G <= '0;
            oDATA_B <= '0;
        end else begin
            oDVAL   <= s1_dval;
            oDATA_R <= pix_r;
            oDATA_G <= pix_g;
            oDATA_B <= pix_b;
        end
    end

    // Saturating accumulation; on a frame boundary the accumulators restart from this cycle's pixel.
    assign take     = s1_dval && dark;
    assign add_x    = {1'b0, sum_x} + SW1'(s1_h);
    assign add_y    = {1'b0, sum_y} + SW1'(s1_v);
    assign add_n    = {1'b0, npix} + NW1'(1);
    assign nxt_x    = !take ? sum_x : (add_x[SUM_W] ? '1 : add_x[SUM_W-1:0]);
    assign nxt_y    = !take ? sum_y : (add_y[SUM_W] ? '1 : add_y[SUM_W-1:0]);
    assign nxt_n    = !take ? npix : (add_n[NPIX_W] ? '1 : add_n[NPIX_W-1:0]);
    assign fresh_x  = take ? SUM_W'(s1_h) : '0;
    assign fresh_y  = take ? SUM_W'(s1_v) : '0;
    assign fresh_n  = take ? NPIX_W'(1) : '0;
    assign boundary = (prev_v != '0) && (iV_Cont == '0);

    // X and Y share one divider: Y is launched in the same cycle X reports done.
    assign div_start = div_kick || ((state == ST_DIV_X) && div_done);

    serial_divider #(
        .DVD_W (SUM_W),
        .DVS_W (NPIX_W)
    ) u_div (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .start    (div_start),
        .dividend (div_kick ? snap_x : snap_y),
        .divisor  (snap_n),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= ST_ACCUM;
            prev_v    <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
            npix      <= '0;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_n    <= '0;
            qx        <= '0;
            low_count <= 1'b0;
            div_kick  <= 1'b0;
            oCX       <= '0;
            oCY       <= '0;
            oPosValid <= 1'b0;
            oDrop     <= 1'b0;
        end else begin
            prev_v   <= iV_Cont;
            oDrop    <= 1'b0;
            div_kick <= 1'b0;
            sum_x    <= nxt_x;
            sum_y    <= nxt_y;
            npix     <= nxt_n;
            if (boundary) begin
                sum_x <= fresh_x;
                sum_y <= fresh_y;
                npix  <= fresh_n;
                if (state == ST_ACCUM) begin
                    snap_x    <= sum_x;
                    snap_y    <= sum_y;
                    snap_n    <= npix;
                    low_count <= (npix < NPIX_W'(MIN_PIX));
                    div_kick  <= !(npix < NPIX_W'(MIN_PIX));
                    state     <= (npix < NPIX_W'(MIN_PIX)) ? ST_UPDATE : ST_DIV_X;
                end else begin
                    oDrop <= 1'b1;
                end
            end
            case (state)
                ST_DIV_X: begin
                    if (div_done) begin
                        qx    <= div_q;
                        state <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done && !div_busy) state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (low_count) begin
                        oPosValid <= 1'b0;
                    end else begin
                        oCX       <= sat_q(qx);
                        oCY       <= sat_q(div_q);
                        oPosValid <= 1'b1;
                    end
                    state <= ST_ACCUM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pupil_locator.sv
// tb/tb_pupil_locator.sv - directed self-checking bench for pupil_locator
module tb_pupil_locator;

    logic        iCLK, iRST, iDVAL, iMarkEn;
    logic [9:0]  iRed, iGreen, iBlue, iThresh;
    logic [12:0] iH_Cont, iV_Cont;
    logic [1:0]  iMode;
    logic        oDVAL, oPosValid, oDrop;
    logic [9:0]  oDATA_R, oDATA_G, oDATA_B;
    logic [12:0] oCX, oCY;
    int          n_checks = 0;
    int          n_fail   = 0;

    pupil_locator dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iDVAL     (iDVAL),
        .iRed      (iRed),
        .iGreen    (iGreen),
        .iBlue     (iBlue),
        .iH_Cont   (iH_Cont),
        .iV_Cont   (iV_Cont),
        .iThresh   (iThresh),
        .iMode     (iMode),
        .iMarkEn   (iMarkEn),
        .oDVAL     (oDVAL),
        .oDATA_R   (oDATA_R),
        .oDATA_G   (oDATA_G),
        .oDATA_B   (oDATA_B),
        .oCX       (oCX),
        .oCY       (oCY),
        .oPosValid (oPosValid),
        .oDrop     (oDrop)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic px(input int h, input int v, input int r, input int g, input int b, input logic dval);
        iH_Cont = 13'(h);
        iV_Cont = 13'(v);
        iRed    = 10'(r);
        iGreen  = 10'(g);
        iBlue   = 10'(b);
        iDVAL   = dval;
        tick();
    endtask

    task automatic block(input int h0, input int nw, input int v0, input int nh);
        for (int y = 0; y < nh; y++)
            for (int x = 0; x < nw; x++)
                px(h0 + x, v0 + y, 0, 0, 0, 1'b1);
    endtask

    // Returns just after the clock edge that closes the boundary cycle.
    task automatic end_frame();
        px(0, 1, 0, 0, 0, 1'b0);
        px(0, 1, 0, 0, 0, 1'b0);
        px(0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic check_xy(input string name, input int ex, input int ey, input logic ev);
        n_checks++;
        if (oCX !== 13'(ex)) begin n_fail++; $display("FAIL %s_cx: got %0d expected %0d", name, oCX, ex); end
        n_checks++;
        if (oCY !== 13'(ey)) begin n_fail++; $display("FAIL %s_cy: got %0d expected %0d", name, oCY, ey); end
        n_checks++;
        if (oPosValid !== ev) begin n_fail++; $display("FAIL %s_valid: got %0b expected %0b", name, oPosValid, ev); end
    endtask

    task automatic test_reset();
        iRST = 1'b0; iThresh = 10'd0; iMode = 2'd0; iMarkEn = 1'b0;
        iH_Cont = 13'd300; iV_Cont = 13'd5; iRed = 10'd512; iGreen = 10'd512; iBlue = 10'd512; iDVAL = 1'b1;
        wait_ticks(3);
        n_checks++;
        if (oDVAL !== 1'b0) begin n_fail++; $display("FAIL reset_dval: got %0b expected 0", oDVAL); end
        n_checks++;
        if ({oDATA_R, oDATA_G, oDATA_B} !== 30'd0) begin n_fail++; $display("FAIL reset_data: got %0d/%0d/%0d expected 0", oDATA_R, oDATA_G, oDATA_B); end
        n_checks++;
        if (oDrop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0b expected 0", oDrop); end
        check_xy("reset", 0, 0, 1'b0);
        iRST = 1'b1;
        tick();
    endtask

    task automatic test_gray();
        int md[10] = '{0, 0, 0, 3, 0, 0, 1, 1, 2, 0};
        int rr[10] = '{512, 512, 100, 100, 100, 100, 512, 512, 100, 512};
        int gg[10] = '{512, 512, 200, 200, 200, 200, 512, 512, 200, 512};
        int bb[10] = '{512, 512, 300, 300, 300, 300, 512, 512, 300, 512};
        int hh[10] = '{300, 100, 256, 639, 640, 255, 300, 300, 400, 300};
        int th[10] = '{0, 0, 0, 0, 0, 0, 513, 512, 0, 0};
        int dv[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int er[10] = '{512, 0, 180, 180, 0, 0, 1023, 0, 100, 512};
        int eg[10] = '{512, 0, 180, 180, 0, 0, 1023, 0, 200, 512};
        int eb[10] = '{512, 0, 180, 180, 0, 0, 1023, 0, 300, 512};
        for (int i = 0; i < 10; i++) begin
            iMode   = 2'(md[i]);
            iThresh = 10'(th[i]);
            px(hh[i], 5, rr[i], gg[i], bb[i], dv[i] != 0);
            tick();
            n_checks++;
            if (oDVAL !== (dv[i] != 0)) begin n_fail++; $display("FAIL pix%0d_dval: got %0b expected %0d", i, oDVAL, dv[i]); end
            n_checks++;
            if (oDATA_R !== 10'(er[i])) begin n_fail++; $display("FAIL pix%0d_r: got %0d expected %0d", i, oDATA_R, er[i]); end
            n_checks++;
            if (oDATA_G !== 10'(eg[i])) begin n_fail++; $display("FAIL pix%0d_g: got %0d expected %0d", i, oDATA_G, eg[i]); end
            n_checks++;
            if (oDATA_B !== 10'(eb[i])) begin n_fail++; $display("FAIL pix%0d_b: got %0d expected %0d", i, oDATA_B, eb[i]); end
        end
    endtask

    task automatic test_centroid();
        iMode = 2'd0; iThresh = 10'd200; iMarkEn = 1'b0;
        end_frame();
        wait_ticks(3);
        block(400, 10, 300, 10);
        end_frame();
        wait_ticks(73);
        check_xy("centroid_early", 0, 0, 1'b0);
        tick();
        check_xy("centroid", 404, 304, 1'b1);
    endtask

    task automatic test_marker();
        iThresh = 10'd100; iMarkEn = 1'b1; iMode = 2'd2;
        px(424, 284, 100, 200, 300, 1'b1);
        tick();
        n_checks++;
        if ({oDATA_R, oDATA_G, oDATA_B} !== 30'd0) begin n_fail++; $display("FAIL marker_corner: got %0d/%0d/%0d expected 0", oDATA_R, oDATA_G, oDATA_B); end
        px(425, 304, 100, 200, 300, 1'b1);
        tick();
        n_checks++;
        if ({oDATA_R, oDATA_G, oDATA_B} !== {10'd100, 10'd200, 10'd300}) begin n_fail++; $display("FAIL marker_outside: got %0d/%0d/%0d expected 100/200/300", oDATA_R, oDATA_G, oDATA_B); end
        iMarkEn = 1'b0;
        px(424, 284, 100, 200, 300, 1'b1);
        tick();
        n_checks++;
        if (oDATA_R !== 10'd100) begin n_fail++; $display("FAIL marker_disabled: got %0d expected 100", oDATA_R); end
        px(0, 5, 0, 0, 0, 1'b0);
    endtask

    task automatic test_min_pix();
        iThresh = 10'd200;
        for (int i = 0; i < 63; i++) px(300 + i, 300, 0, 0, 0, 1'b1);
        end_frame();
        check_xy("minpix_before", 404, 304, 1'b1);
        tick();
        check_xy("minpix", 404, 304, 1'b0);
    endtask

    task automatic test_back_to_back();
        block(500, 4, 200, 16);
        end_frame();
        for (int i = 1; i <= 8; i++) px(600, 0, 0, 0, 0, 1'b1);
        px(0, 7, 0, 0, 0, 1'b0);
        n_checks++;
        if (oDrop !== 1'b0) begin n_fail++; $display("FAIL drop_early: got %0b expected 0", oDrop); end
        px(0, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (oDrop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %0b expected 1", oDrop); end
        tick();
        n_checks++;
        if (oDrop !== 1'b0) begin n_fail++; $display("FAIL drop_width: got %0b expected 0", oDrop); end
        wait_ticks(62);
        check_xy("drop_before", 404, 304, 1'b0);
        tick();
        check_xy("drop_first", 501, 207, 1'b1);
        block(300, 8, 100, 8);
        end_frame();
        wait_ticks(74);
        check_xy("drop_restart", 303, 103, 1'b1);
    endtask

    task automatic test_reset_mid_div();
        block(400, 10, 300, 10);
        end_frame();
        iThresh = 10'd100;
        px(300, 0, 100, 200, 300, 1'b1);
        wait_ticks(49);
        n_checks++;
        if (oDVAL !== 1'b1) begin n_fail++; $display("FAIL middiv_dval: got %0b expected 1", oDVAL); end
        #2;
        iRST = 1'b0;
        #1;
        n_checks++;
        if (oDVAL !== 1'b0) begin n_fail++; $display("FAIL middiv_reset_dval: got %0b expected 0", oDVAL); end
        n_checks++;
        if (oDATA_R !== 10'd0) begin n_fail++; $display("FAIL middiv_reset_r: got %0d expected 0", oDATA_R); end
        check_xy("middiv_reset", 0, 0, 1'b0);
        tick();
        iRST = 1'b1;
        iThresh = 10'd200;
        block(400, 10, 300, 10);
        end_frame();
        wait_ticks(73);
        check_xy("postreset_early", 0, 0, 1'b0);
        tick();
        check_xy("postreset", 404, 304, 1'b1);
    endtask

    initial begin
        test_reset();
        test_gray();
        test_centroid();
        test_marker();
        test_min_pix();
        test_back_to_back();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
